// File: rtl/serial_borrow_subtractor.sv
// Bit-serial N-bit subtractor: Diff = P - Q - Bin, LSB first, through one full-subtractor cell.
// Optional macro SUB_SIGNED_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_borrow_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] P,
  input  logic [N-1:0] Q,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Diff,
  output logic         Bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q, b_q, res_q, diff_q;
  logic [CW-1:0] cnt_q;
  logic          br_q, busy_q, done_q, bout_q;
  logic          diff_bit_d, br_d;

`ifdef SUB_SIGNED_OVF_EN
  logic          p_sign_q, q_sign_q, ovf_q;
`endif

  // NOTE: combinational logic uses blocking '=', state updates in always_ff use '<='.
  always_comb begin
    diff_bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      p_sign_q <= 1'b0;
      q_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= P;
            b_q     <= Q;
            br_q    <= Bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef SUB_SIGNED_OVF_EN
            p_sign_q <= P[N-1];
            q_sign_q <= Q[N-1];
`endif
          end
        end
        SHIFT: begin
          // Result fills from the top so the LSB lands at bit 0 after N shifts.
          res_q <= {diff_bit_d, res_q[N-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          diff_q  <= res_q;
          bout_q  <= br_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
`ifdef SUB_SIGNED_OVF_EN
          ovf_q <= (p_sign_q ^ q_sign_q) & (p_sign_q ^ res_q[N-1]);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor: directed, exhaustive and randomized
// operations compared against an arithmetic reference model.
module tb_serial_borrow_subtractor;

  localparam int N = 4;
  localparam int W = 1 << N;

  logic         clk = 1'b0;
  logic         rst, start, Bin;
  logic [N-1:0] P, Q;
  logic         busy, done, Bout;
  logic [N-1:0] Diff;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  logic [N-1:0] prev_diff;
  logic         prev_bout;
  int n_tests = 0;
  int n_fail  = 0;

  serial_borrow_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .P     (P),
    .Q     (Q),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // {Bout,Diff} as the (N+1)-bit wrap of the plain integer difference.
  function automatic logic [N:0] ref_sub(input int p, input int q, input int b);
    return (N+1)'((p - q - b) & (2 * W - 1));
  endfunction

  // Signed overflow: true signed result falls outside the N-bit two's-complement range.
  function automatic logic ref_ovf(input int p, input int q, input int b);
    int sp, sq, r;
    sp = (p >= W / 2) ? p - W : p;
    sq = (q >= W / 2) ? q - W : q;
    r  = sp - sq - b;
    return (r < -(W / 2)) || (r > (W / 2 - 1));
  endfunction

  // Presents one start; returns #1 after the edge that makes done visible, inputs still set.
  task automatic run_op(input int p, input int q, input int b, input bit hold_start);
    logic [N:0] exp;
    P = N'(p); Q = N'(q); Bin = 1'(b); start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k <= N + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check("busy", 32'(busy), 32'(k < N));
      check("done", 32'(done), 32'(k == N + 1));
      if (k <= N) check("hold_result", 32'({Bout, Diff}), 32'({prev_bout, prev_diff}));
      if (hold_start && k <= N) begin
        P = N'($urandom_range(W - 1, 0));
        Q = N'($urandom_range(W - 1, 0));
        Bin = 1'($urandom_range(1, 0));
      end
    end
    exp = ref_sub(p, q, b);
    check("result", 32'({Bout, Diff}), 32'(exp));
`ifdef SUB_SIGNED_OVF_EN
    check("ovf", 32'(ovf), 32'(ref_ovf(p, q, b)));
`endif
    prev_diff = exp[N-1:0];
    prev_bout = exp[N];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fail_before;
    rst = 1'b1; start = 1'b1; P = 4'd9; Q = 4'd3; Bin = 1'b0;
    prev_diff = '0; prev_bout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("reset_state", 32'({busy, done, Bout, Diff}), 32'(0));
      @(posedge clk); #1;
    end

    run_op(9, 3, 0, 1'b0);
    check("dir_9_3", 32'({Bout, Diff}), 32'({1'b0, 4'd6}));
    run_op(0, 0, 1, 1'b0);
    check("dir_0_0_1", 32'({Bout, Diff}), 32'({1'b1, 4'd15}));
    run_op(3, 9, 0, 1'b0);
    check("dir_3_9", 32'({Bout, Diff}), 32'({1'b1, 4'd10}));

    fail_before = n_fail;
    for (int p = 0; p < W; p++)
      for (int q = 0; q < W; q++)
        for (int b = 0; b < 2; b++)
          run_op(p, q, b, 1'b0);
    $display("[TB] exhaustive pass flag = %0d", (n_fail == fail_before) ? 1 : 0);

    // start held high with operands scrambled while the operation is in flight.
    for (int i = 0; i < 6; i++)
      run_op(int'($urandom_range(W - 1, 0)), int'($urandom_range(W - 1, 0)),
             int'($urandom_range(1, 0)), 1'b1);
    start = 1'b0;

    for (int i = 0; i < 20; i++)
      run_op(int'($urandom_range(W - 1, 0)), int'($urandom_range(W - 1, 0)),
             int'($urandom_range(1, 0)), 1'b0);

    // Mid-operation reset during the second SHIFT cycle.
    run_op(9, 3, 0, 1'b0);
    P = 4'd7; Q = 4'd2; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      check("abort_state", 32'({busy, done, Bout, Diff}), 32'(0));
      @(posedge clk); #1;
    end
    prev_diff = '0; prev_bout = 1'b0;
    run_op(7, 2, 0, 1'b0);
    check("after_abort", 32'({Bout, Diff}), 32'({1'b0, 4'd5}));

`ifdef SUB_SIGNED_OVF_EN
    run_op(8, 1, 0, 1'b0);
    check("ovf_8_1", 32'({ovf, Diff}), 32'({1'b1, 4'd7}));
    run_op(5, 2, 0, 1'b0);
    check("ovf_5_2", 32'({ovf, Diff}), 32'({1'b0, 4'd3}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes Diff = P - Q - Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart of the team's parallel ripple-carry adder. It is area-lean, and it lets a datapath undo an addition without a second parallel adder.
- Operation uses a start/busy/done handshake. The result holds until the next accepted start.

Parameters:
- N, 4, operand width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- P  input  N  minuend; sampled on the accepted start edge.
- Q  input  N  subtrahend; sampled on the accepted start edge.
- Bin  input  1  borrow-in; sampled on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when Diff/Bout are updated.
- Diff  output  N  difference (registered).
- Bout  output  1  borrow-out (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, Diff=0, Bout=0.
  - Internal shift registers, bit counter and borrow flip-flop cleared.
  - rst has priority over every other input, including start in the same cycle.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: latch P->A, Q->B, Bin->br; cnt=0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (busy=1), on each edge:
  - d = A[0]^B[0]^br.
  - br <= (~A[0]&B[0]) | (~(A[0]^B[0])&br).
  - Shift d into the internal result register at its MSB.
  - A and B shift right by one.
  - cnt++.
  - When cnt reaches N-1 on this edge (i.e. the Nth bit is processed), go to DONE.
- DONE (one cycle):
  - Diff <= internal result; Bout <= final br; done=1; busy=0.
  - Go unconditionally to IDLE.
- Diff and Bout change only on the DONE edge. They stay stable during SHIFT and hold indefinitely in IDLE.
- Latency: start sampled at edge t gives busy high for edges t+1 .. t+N. done=1 and Diff/Bout are valid in the cycle after edge t+N+1.
  - Back-to-back throughput: one result per N+2 cycles.
- start while in SHIFT or DONE is ignored and not queued. P/Q/Bin may change freely after the accepted start.
- Arithmetic: {Bout,Diff} == ({1'b0,P} - {1'b0,Q} - Bin) mod 2^(N+1).
  - Bout=1 iff P < Q+Bin; Diff is the unsigned N-bit wrap.
- Reset mid-operation aborts immediately. There is no done pulse and Diff=0 afterwards.

Optional Feature:
- Macro: SUB_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - ovf is reset to 0.
  - ovf is updated with Diff on the DONE edge to (P[N-1]^Q[N-1]) & (P[N-1]^Diff[N-1]), using the latched operand sign bits (two's-complement overflow of P-Q-Bin).
- Not defined: no ovf port and no related logic. The remaining behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, Diff=0, Bout=0 throughout.
- N=4, P=9, Q=3, Bin=0, start 1 cycle -> busy high exactly 4 cycles; done pulses once; Diff=6, Bout=0; done asserts 5 edges after start is sampled.
- P=0, Q=0, Bin=1 -> Diff=15, Bout=1. P=3, Q=9, Bin=0 -> Diff=10, Bout=1.
- Exhaustive: all P, Q in 0..15 and Bin in {0,1}, back-to-back starts -> {Bout,Diff} == (P-Q-Bin) mod 32 every case; a self-checking pass/fail flag is printed at the end.
- start held high continuously, and P changed during SHIFT -> only IDLE-cycle starts are accepted, one result per 6 cycles, results match the latched operands.
- rst asserted on the 2nd SHIFT cycle of P=7, Q=2 -> no done pulse, Diff=0, Bout=0.
- With SUB_SIGNED_OVF_EN: P=8 (-8), Q=1 -> Diff=7, ovf=1. P=5, Q=2 -> Diff=3, ovf=0.
